// File: rtl/bcd_converter_8bit.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one bit per clock).
// Define BCD_SIGNED_EN to treat bin as two's complement and report the sign on neg.
//
//  state | meaning
//  IDLE  | waiting for start; digits hold the last result
//  SHIFT | one add-3/shift iteration per clock (busy)
//  DONE  | one-cycle done pulse, then back to IDLE
module bcd_converter_8bit #(
  parameter int IN_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic [3:0]      hundreds,
  output logic [3:0]      tens,
  output logic [3:0]      ones,
  output logic            neg
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int CNT_W = $clog2(IN_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

  state_t          state, state_nxt;
  logic [IN_W-1:0] shreg;
  logic [IN_W-1:0] operand;
  logic [11:0]     scratch;
  logic [11:0]     adj;
  logic [11:0]     scratch_nxt;
  logic [CNT_W-1:0] cnt;
  logic            last_iter;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  assign adj         = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
  assign scratch_nxt = (adj << 1) | {11'b0, shreg[IN_W-1]};
  assign last_iter   = (cnt == LAST_CNT);

`ifdef BCD_SIGNED_EN
  logic neg_cap;
  // Magnitude stays unsigned 8-bit, so -128 maps to 128.
  assign operand = bin[IN_W-1] ? (~bin + IN_W'(1)) : bin;
`else
  assign operand = bin;
  assign neg     = 1'b0;
`endif

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      scratch  <= '0;
      hundreds <= '0;
      tens     <= '0;
      ones     <= '0;
`ifdef BCD_SIGNED_EN
      neg_cap  <= 1'b0;
      neg      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= operand;
            scratch <= '0;
            cnt     <= '0;
`ifdef BCD_SIGNED_EN
            neg_cap <= bin[IN_W-1];
`endif
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          shreg   <= shreg << 1;
          cnt     <= cnt + 1'b1;
          if (last_iter) begin
            {hundreds, tens, ones} <= scratch_nxt;
`ifdef BCD_SIGNED_EN
            neg <= neg_cap;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bcd_converter_8bit.md
# bcd_converter_8bit

Sequential binary-to-BCD converter for the 8-bit two-function calculator. It converts the 8-bit calculator result into three BCD digits (hundreds, tens, ones) using shift-and-add-3 (double dabble), one bit per clock, under a start/busy/done handshake. It sits directly upstream of the per-digit hex-to-seven-segment decoders: each 4-bit digit output drives one decoder's `{w,x,y,z}` inputs, MSB to `w`.

## Interface
Parameters:
- `IN_W`, 8: input width. Fixed at 8; the digit count and iteration count are derived from it.

Ports:
- `clk`  in  1  single clock; every register updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a conversion; sampled only in IDLE.
- `bin`  in  8  binary operand; captured on the edge that accepts `start`.
- `busy`  out  1  high while a conversion is in progress (SHIFT state).
- `done`  out  1  one-cycle pulse; digit outputs are valid and updated.
- `hundreds`  out  4  BCD hundreds digit (0–2).
- `tens`  out  4  BCD tens digit (0–9).
- `ones`  out  4  BCD ones digit (0–9).
- `neg`  out  1  sign of the operand; constant 0 unless `BCD_SIGNED_EN` is defined.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if `start`=1, load the operand (magnitude) into the shift register, clear the 12-bit BCD scratch, clear the bit counter, and go to SHIFT. If `start`=0, stay in IDLE.
- SHIFT: each cycle performs one iteration:
  - add 3 to any scratch digit that is ≥5;
  - shift `{scratch, operand}` left by 1;
  - increment the counter.
- After the 8th iteration:
  - register the scratch digits into `hundreds`/`tens`/`ones` and update `neg`;
  - go to DONE.
- DONE: `done`=1 for exactly one cycle, then return to IDLE unconditionally.
- `start` is ignored in SHIFT and DONE. It is never queued.
- `bin` changes after capture have no effect on the conversion in progress.
- Digit outputs hold the last result until the next conversion completes. They never show intermediate scratch values.
- Add-3 adjustment is applied to all three digits every iteration. The hundreds digit never exceeds 2, so no carry leaves the 12-bit scratch.
- Reset values: `busy`=0, `done`=0, `hundreds`=`tens`=`ones`=0, `neg`=0. Reset returns the FSM to IDLE and clears the counter and scratch.
- Reset mid-conversion aborts the conversion. No `done` is produced, and outputs return to the reset values.
- `rst` and `start` both high: reset wins.

## Timing
- E0 is the rising edge on which `start` is sampled high in IDLE.
- `busy` rises after E0 and stays high through the cycle ending at E8.
- Edges E1..E8 each perform one iteration.
- At E8: digits and `neg` are updated, `busy` falls, and `done` rises.
- At E9: `done` falls and the FSM is back in IDLE.
- Latency from the start-sample edge to `done` visible is 8 clocks.
- The earliest next start is accepted at E10, so the throughput is one conversion per 10 clocks when `start` is held high.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `BCD_SIGNED_EN` defined:
  - `bin` is two's complement;
  - at capture, `neg` = `bin[7]` and the operand = |`bin|` (8-bit unsigned, so −128 gives 128);
  - `neg` updates at E8 together with the digits.
- `BCD_SIGNED_EN` undefined:
  - `bin` is unsigned 0–255;
  - `neg` is tied to 0 and no negation logic is built.

## Test plan
- Reset, then `start` with `bin`=8'd255 → `busy` high for 8 cycles; `done` pulse 8 clocks after the start edge; digits 2/5/5; `neg`=0.
- `bin`=8'd0, then `bin`=8'd9, then `bin`=8'd100 → 0/0/0, then 0/0/9, then 1/0/0; each shows exactly one `done` pulse.
- Start a conversion of 8'd42, then pulse `start` with `bin`=8'd7 at E3 → only 0/4/2 is produced and there is no second `done`. After the FSM is back in IDLE, a new start with 8'd7 gives 0/0/7.
- After a completed conversion of 8'd123, start 8'd200 and assert `rst` at E4 → `busy`=0, `done` never pulses, digits 0/0/0, next start converts normally.
- With `BCD_SIGNED_EN` defined: `bin`=8'h80 → `neg`=1, digits 1/2/8. `bin`=8'hFF → `neg`=1, digits 0/0/1. `bin`=8'h7F → `neg`=0, digits 1/2/7.
- Without the macro: `bin`=8'h80 → `neg`=0, digits 1/2/8. Hold `start` high continuously → one `done` pulse every 10 clocks.
